// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        input  rx_data, rx_valid,
        output we, waddr, wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  we, waddr, wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian program image from a UART byte stream
// into instruction memory, holding the CPU in reset until the image is complete.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.master bus,
    output logic         cpu_rst,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS - 1) * 33'd4;

    state_t      state, state_nx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_idx;
    logic [31:0] count;
    logic [23:0] pack;
    logic [31:0] hdr_count;
    logic        last_word;

    // Header decision uses the count completed by the byte arriving this cycle.
    assign hdr_count = {bus.rx_data, count[23:0]};
    assign last_word = (word_idx == count - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_rst  = 1'b1;
        case (state)
            S_HDR: begin
                busy = 1'b1;
                if (bus.rx_valid && byte_cnt == 2'd3) begin
                    if (hdr_count == 32'd0)              state_nx = S_DONE;
                    else if (hdr_count > DEPTH_WORDS)    state_nx = S_ERR;
                    else                                 state_nx = S_DATA;
                end
            end
            S_DATA: begin
                busy = 1'b1;
                if (bus.rx_valid && byte_cnt == 2'd3 && last_word) state_nx = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) state_nx = S_HDR;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nx = S_HDR;
            end
            default: state_nx = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= '0;
            word_idx  <= '0;
            count     <= '0;
            pack      <= '0;
            bus.we    <= 1'b0;
            bus.waddr <= BASE_ADDR;
            bus.wdata <= '0;
        end else begin
            assert (!LAST_ADDR[32] && BASE_ADDR[1:0] == 2'b00)
                else $error("imem_loader: BASE_ADDR misaligned or address range overflows");
            bus.we <= 1'b0;
            case (state)
                S_HDR: begin
                    if (bus.rx_valid) begin
                        count[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) word_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: pack[7:0]   <= bus.rx_data;
                            2'd1: pack[15:8]  <= bus.rx_data;
                            2'd2: pack[23:16] <= bus.rx_data;
                            default: begin
                                bus.we    <= 1'b1;
                                bus.wdata <= {bus.rx_data, pack};
                                bus.waddr <= BASE_ADDR + (word_idx << 2);
                                word_idx  <= word_idx + 32'd1;
                            end
                        endcase
                    end
                end
                default: begin
                    if (start) begin
                        byte_cnt <= '0;
                        word_idx <= '0;
                        count    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader against a frame-level reference model.
module tb_imem_loader;
    localparam int unsigned DEPTH = 32768;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        dn;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst, start, cpu_rst, busy, done, error;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    wr_t  obs_q[$];
    int   byte_cyc[$];

    imem_loader_if ifc();

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(ifc.master),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every write pulse is captured with the cycle index of the posedge that raised it.
    always @(negedge clk)
        if (ifc.we === 1'b1) obs_q.push_back('{ifc.waddr, ifc.wdata, done, cyc});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bq_t b, input bit b2b);
        foreach (b[i]) begin
            @(negedge clk);
            ifc.rx_valid = 1'b1;
            ifc.rx_data  = b[i];
            byte_cyc.push_back(cyc + 1);
            if (!b2b) begin
                @(negedge clk);
                ifc.rx_valid = 1'b0;
                ifc.rx_data  = 8'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        @(negedge clk);
        ifc.rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, " rearm busy"},    busy,    1);
        chk({tag, " rearm done"},    done,    0);
        chk({tag, " rearm error"},   error,   0);
        chk({tag, " rearm cpu_rst"}, cpu_rst, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " we"},      ifc.we,    0);
        chk({tag, " waddr"},   ifc.waddr, BASE);
        chk({tag, " wdata"},   ifc.wdata, 0);
        chk({tag, " cpu_rst"}, cpu_rst,   1);
        chk({tag, " busy"},    busy,      1);
        chk({tag, " done"},    done,      0);
        chk({tag, " error"},   error,     0);
    endtask

    function automatic bq_t mk_frame(input int unsigned n, input logic [31:0] words[$]);
        bq_t b;
        for (int k = 0; k < 4; k++) b.push_back(8'(n >> (8 * k)));
        foreach (words[w])
            for (int k = 0; k < 4; k++) b.push_back(8'(words[w] >> (8 * k)));
        return b;
    endfunction

    function automatic bq_t rnd_frame(input int unsigned n);
        logic [31:0] words[$];
        for (int unsigned w = 0; w < n; w++) words.push_back($urandom);
        return mk_frame(n, words);
    endfunction

    // Reference: decode the whole frame and list the writes and final status.
    task automatic check_frame(input string tag, input bq_t b, input bit b2b);
        wr_t         exp[$];
        logic [31:0] n;
        bit          want_done, want_err;
        obs_q.delete();
        byte_cyc.delete();
        send(b, b2b);
        repeat (2) @(negedge clk);
        n = {b[3], b[2], b[1], b[0]};
        want_err  = (n > DEPTH);
        want_done = !want_err;
        if (!want_err)
            for (int unsigned w = 0; w < n; w++)
                exp.push_back('{BASE + 4 * w,
                                {b[4*w+7], b[4*w+6], b[4*w+5], b[4*w+4]},
                                (w == n - 1), byte_cyc[4*w+7]});
        chk({tag, " nwrites"}, obs_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < obs_q.size()) begin
                chk($sformatf("%s waddr[%0d]", tag, i), obs_q[i].addr, exp[i].addr);
                chk($sformatf("%s wdata[%0d]", tag, i), obs_q[i].data, exp[i].data);
                chk($sformatf("%s done_with_we[%0d]", tag, i), obs_q[i].dn, exp[i].dn);
                chk($sformatf("%s we_cycle[%0d]", tag, i), obs_q[i].cyc, exp[i].cyc);
            end
        end
        chk({tag, " done"},    done,    want_done);
        chk({tag, " error"},   error,   want_err);
        chk({tag, " cpu_rst"}, cpu_rst, !want_done);
        chk({tag, " busy"},    busy,    0);
    endtask

    initial begin
        bq_t b;
        rst = 1'b1; start = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_data = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        check_frame("nominal", b, 1'b0);
        if (obs_q.size() == 2) begin
            chk("nominal word0", obs_q[0].data, 32'h0000_0513);
            chk("nominal word1", obs_q[1].data, 32'h0000_006F);
        end
        pulse_start("nominal");

        obs_q.delete();
        b = '{8'h00, 8'h00, 8'h00, 8'h00};
        send(b, 1'b1);
        chk("hdr0 done next cycle", done, 1);
        chk("hdr0 cpu_rst", cpu_rst, 0);
        chk("hdr0 no we", obs_q.size(), 0);

        @(negedge clk); ifc.rx_valid = 1'b1; ifc.rx_data = 8'hAA;
        @(negedge clk); ifc.rx_valid = 1'b0;
        @(negedge clk);
        chk("done ignores rx done", done, 1);
        chk("done ignores rx we", obs_q.size(), 0);
        @(negedge clk); start = 1'b1; ifc.rx_valid = 1'b1; ifc.rx_data = 8'h05;
        @(negedge clk); start = 1'b0; ifc.rx_valid = 1'b0;
        check_frame("start_discard", rnd_frame(1), 1'b0);
        pulse_start("start_discard");

        b = '{8'h01, 8'h80, 8'h00, 8'h00};
        check_frame("oversize", b, 1'b0);
        pulse_start("oversize");
        check_frame("after_err", rnd_frame(1), 1'b0);
        pulse_start("after_err");

        check_frame("b2b4", rnd_frame(4), 1'b1);
        pulse_start("b2b4");

        b = rnd_frame(2);
        b = b[0:9];
        obs_q.delete();
        send(b, 1'b1);
        chk("partial first word written", obs_q.size(), 1);
        obs_q.delete();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midload reset");
        chk("midload no partial we", obs_q.size(), 0);
        rst = 1'b0;
        check_frame("after_midload", rnd_frame(2), 1'b0);
        pulse_start("after_midload");

        b = '{8'h00, 8'h80, 8'h00, 8'h00};
        send(b, 1'b1);
        chk("depth limit busy", busy, 1);
        chk("depth limit error", error, 0);
        chk("depth limit done", done, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        for (int f = 0; f < 6; f++) begin
            check_frame($sformatf("rand%0d", f), rnd_frame($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
            pulse_start($sformatf("rand%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
